// File: rtl/clock_display_pkg.sv
// Shared constants for the six-digit time-of-day display: digit count,
// seven-segment codes (g..a) and per-field limits.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern (active-high, bit0=a); dash overrides.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = 7'h00;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Snapshot + multiplexed six-digit seven-segment scan driver.
// Optional colon blink on dp is enabled by defining DISP_COLON_BLINK_EN.
module clock_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);
  import clock_display_pkg::*;

  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  snap_sec_q, snap_min_q;
  logic [4:0]  snap_hr_q;
  logic [6:0]  seg_q, seg_d;
  logic [5:0]  an_q, an_d;
  logic        dp_q, dp_d;

  logic        slot_en;
  logic [3:0]  digit;
  logic        dash;
  logic [6:0]  code;

  // Anti-ghosting window at the start of each slot; removed entirely when zero.
  if (BLANK_CYC == 0) begin : g_noblank
    assign slot_en = 1'b1;
  end else begin : g_blank
    assign slot_en = (div_q >= 16'(BLANK_CYC));
  end

  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q == 16'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    digit = '0;
    dash  = 1'b0;
    case (idx_q)
      3'd0: begin digit = units_of(snap_sec_q);        dash = (snap_sec_q > SEC_MAX); end
      3'd1: begin digit = tens_of(snap_sec_q);         dash = (snap_sec_q > SEC_MAX); end
      3'd2: begin digit = units_of(snap_min_q);        dash = (snap_min_q > MIN_MAX); end
      3'd3: begin digit = tens_of(snap_min_q);         dash = (snap_min_q > MIN_MAX); end
      3'd4: begin digit = units_of({1'b0, snap_hr_q}); dash = (snap_hr_q > HR_MAX);   end
      3'd5: begin digit = tens_of({1'b0, snap_hr_q});  dash = (snap_hr_q > HR_MAX);   end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .digit (digit),
    .dash  (dash),
    .seg   (code)
  );

  always_comb begin
    an_d  = slot_en ? (6'b000001 << idx_q) : 6'b000000;
    seg_d = slot_en ? code : 7'h00;
`ifdef DISP_COLON_BLINK_EN
    dp_d  = slot_en && ((idx_q == 3'd2) || (idx_q == 3'd4)) && !snap_sec_q[0];
`else
    dp_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      idx_q      <= '0;
      snap_sec_q <= '0;
      snap_min_q <= '0;
      snap_hr_q  <= '0;
      seg_q      <= '0;
      an_q       <= '0;
      dp_q       <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      if (load) begin
        snap_sec_q <= sec;
        snap_min_q <= min;
        snap_hr_q  <= hr;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLANK_CYC=1.
module tb_clock_display_scan;

  logic       clk;
  logic       reset;
  logic       load;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DISP_COLON_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  clock_display_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .sec   (sec),
    .min   (min),
    .hr    (hr),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_digit(input int k);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (an !== (6'b000001 << k) && cyc < 64);
    check_val($sformatf("an_d%0d", k), 32'(an), 32'(6'b000001 << k));
  endtask

  task automatic load_pulse(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    @(negedge clk);
    sec = s; min = m; hr = h; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_scan(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                            input logic sec_even);
    logic [6:0] exp_seg [6];
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2;
    exp_seg[3] = s3; exp_seg[4] = s4; exp_seg[5] = s5;
    for (int k = 0; k < 6; k++) begin
      wait_digit(k);
      check_val($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp_seg[k]));
      check_val($sformatf("%s_dp%0d", tag, k), 32'(dp),
                32'(BLINK && sec_even && (k == 2 || k == 4)));
    end
  endtask

  initial begin
    logic [5:0] exp_an [8];
    int cyc;
    exp_an[0] = 6'h00; exp_an[1] = 6'h01; exp_an[2] = 6'h01; exp_an[3] = 6'h01;
    exp_an[4] = 6'h00; exp_an[5] = 6'h02; exp_an[6] = 6'h02; exp_an[7] = 6'h02;

    reset = 1'b1; load = 1'b0; sec = '0; min = '0; hr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_seg", 32'(seg), 32'h00);
    check_val("rst_an",  32'(an),  32'h00);
    check_val("rst_dp",  32'(dp),  32'h0);

    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("start_an%0d", i), 32'(an), 32'(exp_an[i]));
      check_val($sformatf("start_seg%0d", i), 32'(seg), (exp_an[i] != 0) ? 32'h3F : 32'h00);
    end

    check_scan("zeros", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    load_pulse(6'd58, 6'd59, 5'd23);
    check_scan("t235958", 7'h7F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B, 1'b1);

    load_pulse(6'd60, 6'd5, 5'd24);
    check_scan("range", 7'h40, 7'h40, 7'h6D, 7'h3F, 7'h40, 7'h40, 1'b1);

    // Inputs move without load: display must hold the old snapshot.
    sec = 6'd11; min = 6'd0; hr = 5'd0;
    check_scan("hold", 7'h40, 7'h40, 7'h6D, 7'h3F, 7'h40, 7'h40, 1'b1);

    wait_digit(5);
    wait_digit(0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_val("pulse_old_seg", 32'(seg), 32'h40);
    @(negedge clk);
    check_val("pulse_an", 32'(an), 32'h01);
    check_val("pulse_new_seg", 32'(seg), 32'h06);

    check_scan("sec11", 7'h06, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);

    load_pulse(6'd10, 6'd0, 5'd0);
    check_scan("sec10", 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    wait_digit(2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (an !== 6'h00 && cyc < 16);
    check_val("blank_an",  32'(an),  32'h00);
    check_val("blank_seg", 32'(seg), 32'h00);
    check_val("blank_dp",  32'(dp),  32'h0);

    // Asynchronous reset mid-slot, with a coincident load that must be ignored.
    load_pulse(6'd58, 6'd59, 5'd23);
    wait_digit(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    sec = 6'd45; min = 6'd12; hr = 5'd9; load = 1'b1;
    #1;
    check_val("async_seg", 32'(seg), 32'h00);
    check_val("async_an",  32'(an),  32'h00);
    check_val("async_dp",  32'(dp),  32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (an === 6'h00 && cyc < 16);
    check_val("restart_an", 32'(an), 32'h01);
    check_scan("post_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment driver for the time-of-day counter. It snapshots the binary hours, minutes and seconds on a load strobe and converts each field to two BCD digits. It then time-multiplexes the six digits onto one shared segment bus with per-digit anode enables. It sits between the time counter and the board display pins.

## Interface
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 2..65535.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be < SCAN_DIV; 0 disables blanking.
- clk  in  1  display clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  snapshot strobe; when high at a clk edge, sec/min/hr are captured.
- sec  in  6  binary seconds, valid 0..59.
- min  in  6  binary minutes, valid 0..59.
- hr  in  5  binary hours, valid 0..23.
- seg  out  7  segment drive, active-high, bit0=a .. bit6=g.
- an  out  6  digit enable, active-high one-hot or all-zero; bit0 = rightmost digit (seconds units), bit5 = hours tens.
- dp  out  1  decimal point of the enabled digit, active-high.

## Operation
- Snapshot registers snap_sec, snap_min and snap_hr load when load=1; otherwise they hold their value. load may be held high continuously (transparent tracking).
- Each field is split into a tens digit and a units digit (v/10, v%10). A field above its limit (sec>59, min>59, hr>23) shows dash on both of its digits.
- Digit order by index 0..5: sec units, sec tens, min units, min tens, hr units, hr tens. No leading-zero suppression: 00:00:00 shows six zeros.
- Segment codes (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40.
- Scan counters:
  - div runs 0..SCAN_DIV-1.
  - When div=SCAN_DIV-1, div returns to 0 and idx advances, wrapping 5 to 0.
  - The scan never stops and is independent of load.
- Output function, registered:
  - an = (div>=BLANK_CYC) ? 1<<idx : 0.
  - seg = code of digit idx.
  - dp as in Configuration.
  - While an=0, seg and dp also drive 0.

## Timing
- Reset values: seg=0, an=0, dp=0, div=0, idx=0, snapshot registers all 0.
- Output latency:
  - Outputs at cycle t+1 reflect idx, div and snapshot values present at cycle t.
  - A load at edge t appears on seg at edge t+1 for the currently enabled digit.
- Full scan period: 6*SCAN_DIV cycles. Each digit is enabled for SCAN_DIV-BLANK_CYC consecutive cycles.
- A load mid-slot changes seg within the slot at the timing above. No tearing across fields: all three fields are captured at the same edge.
- Reset asserted mid-scan: all outputs go to 0 immediately, asynchronously. After deassertion the scan restarts at idx 0, div 0.
- Reset and load in the same cycle: reset wins and the snapshot stays 0.

## Configuration
- DISP_COLON_BLINK_EN defined:
  - dp=1 while digit 2 (min units) or digit 4 (hr units) is enabled and snap_sec[0]=0.
  - The colon therefore toggles every displayed second.
- DISP_COLON_BLINK_EN undefined: dp is constant 0; the blink logic is absent.

## Structure
- Package clock_display_pkg:
  - NUM_DIGITS=6.
  - Segment code constants SEG_0..SEG_9 and SEG_DASH.
  - Field limit constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
- Sub-module seg7_decode: combinational, 4-bit digit plus dash flag in, 7-bit seg out. One instance is shared after the digit mux.

## Test plan
- Reset, SCAN_DIV=4, BLANK_CYC=1: during reset seg=00, an=00, dp=0. After release, an=00 for 1 cycle, then 01 for 3 cycles, then 00 for 1 cycle, then 02 for 3 cycles.
- Load hr=23, min=59, sec=58, then walk one scan period. Seg per digit 0..5: 7F, 6D, 6F, 6D, 4F, 5B.
- Load sec=60, min=5, hr=24. Digits 0,1 show 40; digits 2,3 show 6D, 3F; digits 4,5 show 40.
- Change inputs without load: display is unchanged. Pulse load for one cycle: the new value appears on seg one edge later.
- Blink, with DISP_COLON_BLINK_EN:
  - sec=10: dp=1 only while an=04 or an=10.
  - sec=11: dp=0 throughout.
  - Without the macro: dp=0 always.
- Assert reset while idx=3 mid-slot: outputs drop to 0 before the next edge. After release the next enabled anode is 01.
